// File: rtl/spi_byte_master_if.sv
// Byte-transfer request/response bus plus SPI pins between the AHB SPI peripheral and the byte engine.
// The master modport is the requesting side (and the slave device on MISO); the slave modport is the engine.
interface spi_byte_master_if #(
   parameter int SS_WIDTH = 32
);
   logic                start_i;
   logic [7:0]          tx_data_i;
   logic                cpol_i;
   logic                cpha_i;
   logic [1:0]          rate_i;
   logic [SS_WIDTH-1:0] ss_sel_i;
   logic                hold_ss_i;
   logic                spi_miso_i;
   logic                spi_mosi_o;
   logic                spi_clk_o;
   logic [SS_WIDTH-1:0] spi_ss_o;
   logic [7:0]          rx_data_o;
   logic                ready_o;
   logic                done_o;

   modport master (
      output start_i, tx_data_i, cpol_i, cpha_i, rate_i, ss_sel_i, hold_ss_i, spi_miso_i,
      input  spi_mosi_o, spi_clk_o, spi_ss_o, rx_data_o, ready_o, done_o
   );

   modport slave (
      input  start_i, tx_data_i, cpol_i, cpha_i, rate_i, ss_sel_i, hold_ss_i, spi_miso_i,
      output spi_mosi_o, spi_clk_o, spi_ss_o, rx_data_o, ready_o, done_o
   );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode 0-3 byte engine: MSB-first full-duplex byte, busy 18H cycles, done pulse with ready high.
// Backpressure: start_i is only taken while ready_o is high; requests while busy are dropped.
module spi_byte_master #(
   parameter int SS_WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   spi_byte_master_if.slave bus
);

   localparam logic [SS_WIDTH-1:0] SS_IDLE = '1;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t     state_q, state_d;
   logic       cpol_q, cpha_q, hold_q;
   logic [1:0] rate_q;
   logic [7:0] sreg_q;
   logic [2:0] div_q;
   logic [2:0] div_last;
   logic [3:0] cnt_q;
   logic       accept, div_tc, sample, drive;

   always_comb begin
      case (rate_q)
         2'd0:    div_last = 3'd0;
         2'd1:    div_last = 3'd1;
         2'd2:    div_last = 3'd3;
         default: div_last = 3'd7;
      endcase
   end

   // cnt_q is the SCLK edge about to occur minus one: even count = odd edge.
   always_comb begin
      accept = (state_q == IDLE) && bus.start_i;
      div_tc = (div_q == div_last);
      sample = ~cnt_q[0] ^ cpha_q;
      drive  = ~sample && !((cnt_q == 4'd15) && !cpha_q);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   if (div_tc) state_d = SHIFT;
         SHIFT:   if (div_tc && (cnt_q == 4'd15)) state_d = HOLD;
         HOLD:    if (div_tc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cpol_q         <= 1'b0;
         cpha_q         <= 1'b0;
         hold_q         <= 1'b0;
         rate_q         <= 2'd0;
         sreg_q         <= 8'h00;
         div_q          <= 3'd0;
         cnt_q          <= 4'd0;
         bus.spi_clk_o  <= 1'b0;
         bus.spi_mosi_o <= 1'b0;
         bus.spi_ss_o   <= SS_IDLE;
         bus.rx_data_o  <= 8'h00;
         bus.ready_o    <= 1'b1;
         bus.done_o     <= 1'b0;
      end else begin
         bus.done_o <= 1'b0;
         if (state_q == IDLE) div_q <= 3'd0;
         else                 div_q <= div_tc ? 3'd0 : div_q + 3'd1;

         case (state_q)
            IDLE: begin
               if (accept) begin
                  cpol_q        <= bus.cpol_i;
                  cpha_q        <= bus.cpha_i;
                  hold_q        <= bus.hold_ss_i;
                  rate_q        <= bus.rate_i;
                  sreg_q        <= bus.tx_data_i;
                  cnt_q         <= 4'd0;
                  bus.ready_o   <= 1'b0;
                  bus.spi_clk_o <= bus.cpol_i;
                  bus.spi_ss_o  <= ~bus.ss_sel_i;
                  // CPHA=0 needs bit 7 on the wire before the first edge.
                  if (!bus.cpha_i) bus.spi_mosi_o <= bus.tx_data_i[7];
               end
            end
            SHIFT: begin
               if (div_tc) begin
                  bus.spi_clk_o <= ~bus.spi_clk_o;
                  cnt_q         <= cnt_q + 4'd1;
                  if (sample) sreg_q <= {sreg_q[6:0], bus.spi_miso_i};
                  if (drive)  bus.spi_mosi_o <= sreg_q[7];
               end
            end
            HOLD: begin
               if (div_tc) begin
                  bus.rx_data_o <= sreg_q;
                  bus.done_o    <= 1'b1;
                  bus.ready_o   <= 1'b1;
                  if (!hold_q) bus.spi_ss_o <= SS_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: loopback and a mode-aware SPI slave model on MISO.
module tb_spi_byte_master;

   logic clk;
   logic rstn;
   int   n_checks = 0;
   int   n_fail   = 0;

   spi_byte_master_if #(.SS_WIDTH(32)) bus();

   spi_byte_master #(.SS_WIDTH(32)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave / observer state
   logic       loop_en = 1'b1;
   logic       slv_cpol = 1'b0;
   logic       slv_cpha = 1'b0;
   logic [7:0] slv_data = 8'h00;
   logic       slv_miso = 1'b0;
   logic       prev_sclk = 1'b0;
   int         edge_cnt = 0;
   int         last_edges = 0;
   logic [7:0] mosi_bits = 8'h00;
   logic [7:0] last_mosi = 8'h00;
   int         done_cnt = 0;
   int         cyc = 0;
   int         last_edge_cyc = 0;
   int         gmin = 0, gmax = 0, last_gmin = 0, last_gmax = 0;

   assign bus.spi_miso_i = loop_en ? bus.spi_mosi_o : slv_miso;

   always @(negedge clk) begin
      int idx;
      cyc++;
      if (bus.ready_o) begin
         if (edge_cnt != 0) begin
            last_edges = edge_cnt;
            last_mosi  = mosi_bits;
            last_gmin  = gmin;
            last_gmax  = gmax;
         end
         edge_cnt  = 0;
         mosi_bits = 8'h00;
         gmin      = 1000;
         gmax      = 0;
         prev_sclk = slv_cpol;
      end else if (bus.spi_clk_o !== prev_sclk) begin
         edge_cnt++;
         if (edge_cnt > 1) begin
            if (cyc - last_edge_cyc < gmin) gmin = cyc - last_edge_cyc;
            if (cyc - last_edge_cyc > gmax) gmax = cyc - last_edge_cyc;
         end
         last_edge_cyc = cyc;
         if ((edge_cnt[0] == 1'b1) != slv_cpha) mosi_bits = {mosi_bits[6:0], bus.spi_mosi_o};
         prev_sclk = bus.spi_clk_o;
      end
      // Slave shifts its next bit on the edge opposite the master's sampling edge.
      if (!slv_cpha) idx = 7 - edge_cnt / 2;
      else           idx = (edge_cnt == 0) ? 7 : 7 - (edge_cnt - 1) / 2;
      slv_miso = (idx >= 0) ? slv_data[idx] : 1'b0;
      if (bus.done_o) done_cnt++;
   end

   task automatic xfer(input logic [7:0] tx, input logic cpol, input logic cpha,
                       input logic [1:0] rate, input logic [31:0] sel, input logic hold,
                       output int busy, output bit ss_ok, output bit done_seen,
                       output logic [31:0] ss_before, output logic [31:0] ss_after);
      slv_cpol = cpol;
      slv_cpha = cpha;
      for (int i = 0; i < 300 && !bus.ready_o; i++) @(negedge clk);
      @(negedge clk);
      ss_before        = bus.spi_ss_o;
      bus.tx_data_i    = tx;
      bus.cpol_i       = cpol;
      bus.cpha_i       = cpha;
      bus.rate_i       = rate;
      bus.ss_sel_i     = sel;
      bus.hold_ss_i    = hold;
      bus.start_i      = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      busy  = 0;
      ss_ok = 1'b1;
      while (!bus.ready_o && busy < 200) begin
         busy++;
         if (bus.spi_ss_o !== ~sel) ss_ok = 1'b0;
         @(negedge clk);
      end
      done_seen = bus.done_o;
      ss_after  = bus.spi_ss_o;
      #1;
   endtask

   int          busy;
   bit          ss_ok, done_seen;
   logic [31:0] ss_b, ss_a;

   task automatic test_reset();
      rstn = 1'b0;
      bus.start_i = 1'b0; bus.tx_data_i = 8'h00; bus.cpol_i = 1'b0; bus.cpha_i = 1'b0;
      bus.rate_i = 2'd0; bus.ss_sel_i = 32'h0; bus.hold_ss_i = 1'b0;
      #23;
      n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
      n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
      n_checks++; if (bus.spi_clk_o !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", bus.spi_clk_o); end
      n_checks++; if (bus.spi_mosi_o !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", bus.spi_mosi_o); end
      n_checks++; if (bus.spi_ss_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_ss: got %h want ffffffff", bus.spi_ss_o); end
      n_checks++; if (bus.rx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_rx: got %h want 00", bus.rx_data_o); end
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (bus.ready_o !== 1'b1 || bus.spi_ss_o !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL post_reset_idle: ready %b ss %h want 1 ffffffff", bus.ready_o, bus.spi_ss_o); end
   endtask

   task automatic test_mode0_loopback();
      loop_en = 1'b1;
      xfer(8'hA5, 1'b0, 1'b0, 2'd0, 32'h1, 1'b0, busy, ss_ok, done_seen, ss_b, ss_a);
      n_checks++; if (busy !== 18) begin n_fail++; $display("FAIL m0_busy: got %0d want 18", busy); end
      n_checks++; if (!ss_ok) begin n_fail++; $display("FAIL m0_ss_during: got deviation want fffffffe"); end
      n_checks++; if (!done_seen) begin n_fail++; $display("FAIL m0_done: got 0 want 1"); end
      n_checks++; if (bus.rx_data_o !== 8'hA5) begin n_fail++; $display("FAIL m0_rx: got %h want a5", bus.rx_data_o); end
      n_checks++; if (last_edges !== 16) begin n_fail++; $display("FAIL m0_edges: got %0d want 16", last_edges); end
      n_checks++; if (last_mosi !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi: got %h want a5", last_mosi); end
      n_checks++; if (ss_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL m0_ss_release: got %h want ffffffff", ss_a); end
   endtask

   task automatic test_mode3_slave();
      loop_en  = 1'b0;
      slv_data = 8'h3C;
      xfer(8'hF0, 1'b1, 1'b1, 2'd2, 32'h1, 1'b0, busy, ss_ok, done_seen, ss_b, ss_a);
      n_checks++; if (busy !== 72) begin n_fail++; $display("FAIL m3_busy: got %0d want 72", busy); end
      n_checks++; if (bus.rx_data_o !== 8'h3C) begin n_fail++; $display("FAIL m3_rx: got %h want 3c", bus.rx_data_o); end
      n_checks++; if (last_mosi !== 8'hF0) begin n_fail++; $display("FAIL m3_mosi: got %h want f0", last_mosi); end
      n_checks++; if (last_edges !== 16) begin n_fail++; $display("FAIL m3_edges: got %0d want 16", last_edges); end
      n_checks++; if (last_gmin !== 4 || last_gmax !== 4) begin
         n_fail++; $display("FAIL m3_halfperiod: got %0d..%0d want 4..4", last_gmin, last_gmax); end
      n_checks++; if (bus.spi_clk_o !== 1'b1) begin n_fail++; $display("FAIL m3_sclk_idle: got %b want 1", bus.spi_clk_o); end
   endtask

   task automatic test_modes_1_2();
      loop_en = 1'b1;
      xfer(8'h81, 1'b0, 1'b1, 2'd1, 32'h1, 1'b0, busy, ss_ok, done_seen, ss_b, ss_a);
      n_checks++; if (bus.rx_data_o !== 8'h81 || busy !== 36) begin
         n_fail++; $display("FAIL m1_loop: got rx %h busy %0d want 81 36", bus.rx_data_o, busy); end
      xfer(8'h81, 1'b1, 1'b0, 2'd0, 32'h1, 1'b0, busy, ss_ok, done_seen, ss_b, ss_a);
      n_checks++; if (bus.rx_data_o !== 8'h81 || busy !== 18) begin
         n_fail++; $display("FAIL m2_loop: got rx %h busy %0d want 81 18", bus.rx_data_o, busy); end
      loop_en  = 1'b0;
      slv_data = 8'h6B;
      xfer(8'h00, 1'b1, 1'b0, 2'd0, 32'h1, 1'b0, busy, ss_ok, done_seen, ss_b, ss_a);
      n_checks++; if (bus.rx_data_o !== 8'h6B) begin n_fail++; $display("FAIL m2_slave_rx: got %h want 6b", bus.rx_data_o); end
      slv_data = 8'hC6;
      xfer(8'h00, 1'b0, 1'b1, 2'd0, 32'h1, 1'b0, busy, ss_ok, done_seen, ss_b, ss_a);
      n_checks++; if (bus.rx_data_o !== 8'hC6) begin n_fail++; $display("FAIL m1_slave_rx: got %h want c6", bus.rx_data_o); end
      loop_en = 1'b1;
   endtask

   task automatic test_back_to_back();
      int dones, first_at, gap;
      logic [7:0] rx1, rx2;
      dones = 0; first_at = 0; gap = 0; rx1 = 8'h00; rx2 = 8'h00;
      loop_en = 1'b1; slv_cpol = 1'b0; slv_cpha = 1'b0;
      @(negedge clk);
      bus.tx_data_i = 8'h12; bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; bus.rate_i = 2'd0;
      bus.ss_sel_i = 32'h1; bus.hold_ss_i = 1'b0; bus.start_i = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (c == 5) begin bus.tx_data_i = 8'hFF; bus.cpha_i = 1'b1; bus.rate_i = 2'd3; end
         if (bus.done_o) begin
            dones++;
            if (dones == 1) begin
               first_at = c; rx1 = bus.rx_data_o;
               bus.tx_data_i = 8'h34; bus.cpha_i = 1'b0; bus.rate_i = 2'd0;
            end else if (dones == 2) begin
               gap = c - first_at; rx2 = bus.rx_data_o; bus.start_i = 1'b0;
            end
         end
      end
      n_checks++; if (dones !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
      n_checks++; if (rx1 !== 8'h12) begin n_fail++; $display("FAIL b2b_rx1: got %h want 12", rx1); end
      n_checks++; if (rx2 !== 8'h34) begin n_fail++; $display("FAIL b2b_rx2: got %h want 34", rx2); end
      n_checks++; if (gap !== 19) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 19", gap); end
   endtask

   task automatic test_hold_ss();
      logic [7:0]  bytes [4];
      logic [31:0] exp_b, exp_a;
      bytes[0] = 8'hDE; bytes[1] = 8'hAD; bytes[2] = 8'hBE; bytes[3] = 8'hEF;
      loop_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         xfer(bytes[i], 1'b0, 1'b0, 2'd0, 32'h4, (i != 3), busy, ss_ok, done_seen, ss_b, ss_a);
         exp_b = (i == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFB;
         exp_a = (i == 3) ? 32'hFFFF_FFFF : 32'hFFFF_FFFB;
         n_checks++; if (bus.rx_data_o !== bytes[i] || !ss_ok) begin
            n_fail++; $display("FAIL hold_byte%0d: got rx %h ss_ok %b want %h 1", i, bus.rx_data_o, ss_ok, bytes[i]); end
         n_checks++; if (ss_b !== exp_b || ss_a !== exp_a) begin
            n_fail++; $display("FAIL hold_ss%0d: got %h/%h want %h/%h", i, ss_b, ss_a, exp_b, exp_a); end
      end
   endtask

   task automatic test_reset_mid_shift();
      int d0;
      loop_en = 1'b1; slv_cpol = 1'b0; slv_cpha = 1'b0;
      @(negedge clk);
      bus.tx_data_i = 8'h99; bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; bus.rate_i = 2'd0;
      bus.ss_sel_i = 32'h1; bus.hold_ss_i = 1'b0; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (7) @(negedge clk);
      @(posedge clk);
      #1 rstn = 1'b0;
      d0 = done_cnt;
      #1;
      n_checks++; if (bus.spi_clk_o !== 1'b0 || bus.spi_mosi_o !== 1'b0 || bus.spi_ss_o !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL rst_mid_pins: got sclk %b mosi %b ss %h want 0 0 ffffffff",
                            bus.spi_clk_o, bus.spi_mosi_o, bus.spi_ss_o); end
      n_checks++; if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.rx_data_o !== 8'h00) begin
         n_fail++; $display("FAIL rst_mid_status: got ready %b done %b rx %h want 1 0 00",
                            bus.ready_o, bus.done_o, bus.rx_data_o); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (25) @(negedge clk);
      n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt - d0); end
      xfer(8'h55, 1'b0, 1'b0, 2'd0, 32'h1, 1'b0, busy, ss_ok, done_seen, ss_b, ss_a);
      n_checks++; if (bus.rx_data_o !== 8'h55 || busy !== 18 || !done_seen) begin
         n_fail++; $display("FAIL rst_mid_recover: got rx %h busy %0d done %b want 55 18 1",
                            bus.rx_data_o, busy, done_seen); end
   endtask

   initial begin
      test_reset();
      test_mode0_loopback();
      test_mode3_slave();
      test_modes_1_2();
      test_back_to_back();
      test_hold_ss();
      test_reset_mid_shift();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_byte_master.md
# spi_byte_master

Byte-serial SPI master engine that sits directly downstream of the AHB SPI peripheral and is driven by it. It accepts one 8-bit transmit byte per start handshake, shifts it out MSB-first on MOSI in SPI mode 0–3, and captures 8 bits from MISO in the same transfer. Its clock divider, selectable slave-select line and optional SS hold let the peripheral issue multi-byte (1/2/4-byte) writes as back-to-back byte transfers.

## Interface
- SS_WIDTH, 32, number of active-low slave-select lines
- clk_i  in  1  system clock (HCLK domain); all logic on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  transfer request; accepted only on a cycle with start_i=1 and ready_o=1
- tx_data_i  in  8  byte to transmit; latched on accept
- cpol_i  in  1  SCLK idle level; latched on accept
- cpha_i  in  1  0: sample on leading edge, 1: sample on trailing edge; latched on accept
- rate_i  in  2  divider select; half-period H = 2^rate_i clk_i cycles (1/2/4/8); latched on accept
- ss_sel_i  in  SS_WIDTH  one-hot select; bit n=1 drives spi_ss_o[n] low during transfer; latched on accept
- hold_ss_i  in  1  keep SS asserted after this byte completes; latched on accept
- spi_miso_i  in  1  serial data from slave
- spi_mosi_o  out  1  serial data to slave
- spi_clk_o  out  1  SCLK
- spi_ss_o  out  SS_WIDTH  active-low slave selects
- rx_data_o  out  8  byte received in last completed transfer
- ready_o  out  1  engine idle, able to accept start_i
- done_o  out  1  one-cycle pulse on completion

## Operation
- States: IDLE, SETUP, SHIFT, HOLD. All outputs registered.
- Reset values: spi_clk_o=0, spi_mosi_o=0, spi_ss_o=all ones, rx_data_o=0x00, ready_o=1, done_o=0, state IDLE, held-SS flag 0.
- IDLE: ready_o=1, spi_clk_o=latched CPOL. On accept: latch all config, load shift register with tx_data_i, go SETUP, ready_o->0.
- SETUP (H cycles): spi_ss_o = ~ss_sel latched; spi_clk_o = CPOL. CPHA=0: spi_mosi_o = bit 7 from first SETUP cycle. CPHA=1: MOSI changes on first SCLK edge.
- SHIFT (16H cycles): SCLK toggles every H cycles, 16 edges total, ending at CPOL. CPHA=0: sample MISO on odd edges (1,3,..15), shift next bit out on even edges 2..14. CPHA=1: drive bit on odd edges, sample on even edges.
- HOLD (H cycles): SCLK at CPOL; then rx_data_o <= captured byte, done_o=1 for one cycle, return IDLE, ready_o=1.
- SS release: on leaving HOLD, spi_ss_o -> all ones unless latched hold_ss=1; if held, SS stays asserted in IDLE until the next accepted transfer (which re-drives SS from its own ss_sel_i) completes with hold_ss_i=0.
- Bit counter 4-bit edge count (0..15); divider counter 3-bit, terminal value H-1.
- Illegal ss_sel_i (zero or multi-hot) driven through unchanged; no checking.

## Timing
- Accept at clk edge k; ready_o low from k+1; busy exactly 18H cycles (SETUP H + SHIFT 16H + HOLD H).
- done_o high and rx_data_o updated in the same cycle, ready_o=1 that cycle; back-to-back start_i in that cycle is accepted (throughput 18H+1 cycles/byte).
- start_i while ready_o=0 ignored, no latching, no effect on in-flight transfer.
- Config inputs changing mid-transfer have no effect.
- rx_data_o stable between done_o pulses.
- rstn_i low at any point: all outputs to reset values immediately (asynchronous), transfer discarded, no done_o; first accept possible on first edge after rstn_i deasserts.
- SCLK frequency = clk_i / (2H); max clk_i/2 at rate_i=0.

## Test plan
- Loopback MOSI->MISO, mode 0 (cpol=0,cpha=0), rate 0, tx 0xA5, ss_sel=0x1 -> ready_o low 18 cycles, 16 SCLK edges, spi_ss_o=0xFFFFFFFE during transfer, done_o pulse, rx_data_o=0xA5, SS back to all ones.
- Slave model returning 0x3C, mode 3, rate 2 (H=4), tx 0xF0 -> SCLK idles high, period 8 cycles, busy 72 cycles, MOSI bitstream 1,1,1,1,0,0,0,0, rx_data_o=0x3C.
- Modes 1 and 2 with loopback, tx 0x81 -> rx 0x81; MISO sampled on correct edge (checker flags sample on wrong edge).
- start_i held high throughout, tx 0x12 then 0x34 -> second byte accepted in done_o cycle, exactly two done_o pulses; start pulse mid-transfer ignored.
- hold_ss_i=1 for 4 bytes 0xDE,0xAD,0xBE,0xEF on ss_sel=0x4, last byte hold=0 -> spi_ss_o[2] low continuously across all four, released after final HOLD.
- rstn_i asserted at SHIFT edge 7 -> outputs to reset values same cycle, no done_o, next transfer 0x55 completes correctly.
